// File: rtl/wallace_divider.sv
// wallace_divider: sequential restoring divider, one quotient bit per clock.
// Divides a 2*DW-bit unsigned dividend by a DW-bit unsigned divisor and
// returns a DW-bit quotient and remainder. It is the inverse of the wallace
// multiplier, so a*b / b == a round-trips.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active-high
//   in_valid     dividend/divisor valid
//   in_ready     divider idle, can accept a new operation
//   dividend     2*DW-bit unsigned numerator
//   divisor      DW-bit unsigned denominator
//   out_valid    result valid; held until out_ready
//   out_ready    consumer accepts result
//   quotient     DW-bit unsigned quotient
//   remainder    DW-bit unsigned remainder
//   div_by_zero  divisor was zero (qualified by out_valid)
//   overflow     quotient does not fit in DW bits (qualified by out_valid)
module wallace_divider #(
  parameter int unsigned DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*DW-1:0] dividend,
  input  logic [DW-1:0]   divisor,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   quotient,
  output logic [DW-1:0]   remainder,
  output logic            div_by_zero,
  output logic            overflow
);

  localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic [DW-1:0]   quotient_q;
  logic [DW-1:0]   remainder_q;
  logic            div_by_zero_q;
  logic            overflow_q;

  // Partial remainder, quotient/dividend shift register, latched divisor.
  logic [DW-1:0]   prem_q;
  logic [DW-1:0]   shq_q;
  logic [DW-1:0]   dsr_q;
  logic [CW-1:0]   cnt_q;

  logic [DW:0]     trial;
  logic            no_borrow;
  logic [DW-1:0]   sub;
  logic [DW-1:0]   prem_d;
  logic [DW-1:0]   shq_d;

  // One restoring step. The partial remainder is always below the divisor,
  // so the trial value fits DW+1 bits and the difference, when taken, fits DW.
  always_comb begin
    trial     = {prem_q, shq_q[DW-1]};
    no_borrow = (trial >= {1'b0, dsr_q});
    sub       = trial[DW-1:0] - dsr_q;
    prem_d    = no_borrow ? sub : trial[DW-1:0];
    shq_d     = {shq_q[DW-2:0], no_borrow};
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
      overflow_q    <= 1'b0;
      prem_q        <= '0;
      shq_q         <= '0;
      dsr_q         <= '0;
      cnt_q         <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            dsr_q      <= divisor;
            in_ready_q <= 1'b0;
            if (divisor == '0) begin
              state_q       <= DONE;
              out_valid_q   <= 1'b1;
              div_by_zero_q <= 1'b1;
              overflow_q    <= 1'b0;
              quotient_q    <= '1;
              remainder_q   <= dividend[DW-1:0];
            end else if (dividend[2*DW-1:DW] >= divisor) begin
              // Upper half already >= divisor: quotient needs more than DW bits.
              state_q       <= DONE;
              out_valid_q   <= 1'b1;
              div_by_zero_q <= 1'b0;
              overflow_q    <= 1'b1;
              quotient_q    <= '1;
              remainder_q   <= '0;
            end else begin
              state_q <= RUN;
              prem_q  <= dividend[2*DW-1:DW];
              shq_q   <= dividend[DW-1:0];
              cnt_q   <= '0;
            end
          end
        end
        RUN: begin
          prem_q <= prem_d;
          shq_q  <= shq_d;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == CW'(DW - 1)) begin
            state_q       <= DONE;
            out_valid_q   <= 1'b1;
            quotient_q    <= shq_d;
            remainder_q   <= prem_d;
            div_by_zero_q <= 1'b0;
            overflow_q    <= 1'b0;
          end
        end
        DONE: begin
          // Result registers hold after the handshake; only valid drops.
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_wallace_divider.sv
// Scoreboard bench for wallace_divider: the driver pushes reference results
// computed with plain 64-bit division; a monitor pops on each new out_valid.
module tb_wallace_divider;

  localparam int unsigned DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [2*DW-1:0] dividend;
  logic [DW-1:0]   divisor;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   quotient;
  logic [DW-1:0]   remainder;
  logic            div_by_zero;
  logic            overflow;

  wallace_divider #(.DW(DW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] q;
    logic [DW-1:0] r;
    logic          dbz;
    logic          ovf;
    int            acc;
    int            lat;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   rand_ready = 1'b0;
  bit   checked = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain arithmetic on the full-width operands.
  function automatic exp_t model(input logic [63:0] n, input logic [31:0] d);
    exp_t e;
    e.acc = 0;
    e.lat = DW;
    e.dbz = 1'b0;
    e.ovf = 1'b0;
    if (d == 0) begin
      e.q = '1; e.r = n[31:0]; e.dbz = 1'b1; e.lat = 0;
    end else if ((n >> 32) >= {32'd0, d}) begin
      e.q = '1; e.r = '0; e.ovf = 1'b1; e.lat = 0;
    end else begin
      e.q = 32'(n / {32'd0, d});
      e.r = 32'(n % {32'd0, d});
    end
    return e;
  endfunction

  // Random consumer backpressure when enabled.
  always @(negedge clk) if (rand_ready) out_ready = 1'($urandom_range(0, 1));

  // Monitor: check each result once on arrival, then stability while held,
  // and that outputs hold their values after the handshake.
  always @(negedge clk) begin
    if (rst) begin
      checked = 1'b0;
    end else if (out_valid && !checked) begin
      checked = 1'b1;
      if (sb.size() == 0) begin
        chk("unexpected_result", 64'(out_valid), 64'd0);
      end else begin
        cur = sb.pop_front();
        chk("quotient", 64'(quotient), 64'(cur.q));
        chk("remainder", 64'(remainder), 64'(cur.r));
        chk("div_by_zero", 64'(div_by_zero), 64'(cur.dbz));
        chk("overflow", 64'(overflow), 64'(cur.ovf));
        chk("latency", 64'(cyc - cur.acc), 64'(cur.lat));
      end
    end else if (out_valid && checked) begin
      chk("held_quotient", 64'(quotient), 64'(cur.q));
      chk("held_remainder", 64'(remainder), 64'(cur.r));
      chk("held_flags", 64'({div_by_zero, overflow}), 64'({cur.dbz, cur.ovf}));
    end else if (!out_valid && checked) begin
      checked = 1'b0;
      chk("post_hs_quotient", 64'(quotient), 64'(cur.q));
      chk("post_hs_remainder", 64'(remainder), 64'(cur.r));
    end
  end

  // Present one operation and wait (bounded) for it to be accepted.
  task automatic issue(input logic [63:0] n, input logic [31:0] d);
    exp_t e;
    int   guard = 0;
    @(negedge clk);
    dividend = n;
    divisor  = d;
    in_valid = 1'b1;
    while (!in_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 64'(in_ready), 64'd1);
    end else begin
      e = model(n, d);
      e.acc = cyc + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while ((sb.size() != 0 || out_valid) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_quotient"}, 64'(quotient), 64'd0);
    chk({tag, "_remainder"}, 64'(remainder), 64'd0);
    chk({tag, "_flags"}, 64'({div_by_zero, overflow}), 64'd0);
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] a;
    logic [63:0] n;
    int          guard;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;

    // Directed cases.
    issue(64'd174667200000, 32'd1200000);
    drain();
    issue(64'd174667200007, 32'd1200000);
    drain();
    issue(64'hFFFFFFFE_00000001, 32'hFFFFFFFF);
    drain();
    issue(64'd99, 32'd0);
    drain();
    issue(64'h1_00000000, 32'd1);
    drain();

    // Backpressure in DONE, and in_valid pulses while busy.
    out_ready = 1'b0;
    issue(64'd174667200007, 32'd1200000);
    dividend = 64'd12345; divisor = 32'd0;
    guard = 0;
    while (!out_valid && guard < 100) begin
      in_valid = 1'($urandom_range(0, 1));
      chk("busy_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
      guard++;
    end
    chk("wait_out_valid", 64'(out_valid), 64'd1);
    repeat (5) begin
      in_valid = 1'b1;
      chk("done_in_ready", 64'(in_ready), 64'd0);
      chk("done_out_valid", 64'(out_valid), 64'd1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("hs_out_valid", 64'(out_valid), 64'd0);
    chk("hs_in_ready", 64'(in_ready), 64'd1);
    drain();

    // Reset in the middle of a run (iteration count 10).
    issue(64'd174667200000, 32'd1200000);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    check_reset_state("midrun_reset");
    rst = 1'b0;
    issue(64'd174667200000, 32'd1200000);
    drain();

    // Randomized operations with random consumer backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0: begin d = 32'd0; n = {$urandom, $urandom}; end
        1: begin d = $urandom | 32'd1; n = {$urandom_range(0, 32'hFFFF) + d, $urandom}; end
        2: begin a = $urandom; d = $urandom | 32'd1; n = 64'(a) * 64'(d); end
        3: begin d = 32'($urandom_range(1, 255)); n = {32'($urandom) % d, $urandom}; end
        default: begin d = $urandom | 32'd1; n = {32'($urandom) % d, $urandom}; end
      endcase
      issue(n, d);
    end
    drain();
    rand_ready = 1'b0;
    out_ready = 1'b1;
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
